pe_psum_drain: RTL
==================

// Module: pe_psum_drain
// PURPOSE
//  Downstream stage of the PE reducer. On the reducer's finish pulse, snapshots all NUM_BUF signed
//  partial-sum buffers. Requantizes each one (optional ReLU, rounding right-shift, signed saturate
//  to OUT_W) and streams the results out one per beat, using a valid/ready handshake, to the
//  activation writeback.
// PARAMETERS
//  NUM_BUF  10  number of partial-sum buffers produced by the reducer
//  PSUM_W   36  partial-sum width (signed two's complement)
//  OUT_W    16  output activation width (signed)
//  SHIFT_W  6   width of the runtime shift amount
// PORTS
//  i_clk      in   1                 clock, rising edge
//  i_rst      in   1                 synchronous reset, active-high
//  i_finish   in   1                 one-cycle pulse from reducer: i_buf is final
//  i_buf      in   NUM_BUF x PSUM_W  partial sums, valid in the i_finish cycle
//  i_relu_en  in   1                 clamp negative sums to 0 before shift; sampled with i_finish
//  i_shift    in   SHIFT_W           right-shift amount, 0..PSUM_W-1; sampled with i_finish
//  i_ready    in   1                 downstream accepts o_data this cycle
//  o_valid    out  1                 o_data/o_idx/o_last valid
//  o_data     out  OUT_W             requantized activation
//  o_idx      out  $clog2(NUM_BUF)   buffer index of o_data
//  o_last     out  1                 o_idx == NUM_BUF-1
//  o_busy     out  1                 snapshot held, drain in progress
//  o_done     out  1                 one-cycle pulse after last beat accepted
//  o_overrun  out  1                 sticky: i_finish arrived while busy and was dropped
// BEHAVIOUR
//  Reset: every output is 0; FSM goes to IDLE; the snapshot regs and the sampled relu/shift are cleared.
//  Reset mid-drain: takes effect at the next edge and aborts the drain. No o_done is produced.
//  FSM states: IDLE, DRAIN.
//   IDLE: on i_finish, latch i_buf, i_relu_en and i_shift, and go to DRAIN. At that edge set
//    idx=0, o_valid=1, o_busy=1. First beat is on the cycle after i_finish (latency 1).
//   DRAIN: a beat is accepted on an edge where o_valid && i_ready.
//    Accept with idx<NUM_BUF-1: idx++ and o_data updates at the same edge. There are no bubbles.
//    Accept with idx==NUM_BUF-1: o_valid=0, o_busy=0, o_done=1 for one cycle, go to IDLE.
//   Not accepted: o_valid, o_data, o_idx and o_last hold stable. The AXI-style rule applies:
//   o_valid never drops without an accept.
//  Simultaneous events:
//   i_finish on the same edge as the final accept: new snapshot is taken, and FSM stays in DRAIN
//    with idx=0. o_done still pulses.
//   i_finish in DRAIN at any other time: ignored; o_overrun=1 until reset.
//   i_finish in IDLE while i_ready=0: snapshot taken normally; ready does not matter in IDLE.
//  Requant per element x (signed PSUM_W), combinational on the snapshot and idx:
//   r  = (relu && x<0) ? 0 : x
//   s  = (shift==0) ? r : (r + (1<<(shift-1))) >>> shift  (arithmetic shift; round half toward +inf;
//        intermediate is PSUM_W+1 bits so the add never overflows)
//   o  = saturate s to [-2^(OUT_W-1), 2^(OUT_W-1)-1]
//  o_data is registered: the value for the next idx is computed and loaded on the accept edge.
//  i_shift >= PSUM_W is undefined; the bench must not drive it.
// STRUCTURE
//  pe_pkg (shared): PSUM_W, NUM_BUF, OUT_W localparams; typedef logic signed [PSUM_W-1:0] psum_t;
//   typedef enum logic {IDLE, DRAIN} drain_state_e. The reducer also uses psum_t.
//  Sub-module pe_requant: purely combinational ReLU/round/saturate; input psum_t, relu, shift;
//   output OUT_W. Instantiated once and muxed by idx; it is reused by later writeback stages.
//  Top: FSM, snapshot register array, idx counter, output register, sticky overrun flag.
// TESTING
//  1 Basic drain, SHIFT=0, relu=0, i_ready=1: buf={45,32,39,6,0..} -> 10 beats on consecutive
//    cycles 1..10 after finish. o_data=45,32,39,6,0,...; o_last only on idx 9; o_done on cycle 11.
//  2 Rounding/sat: buf[0]=383, buf[1]=384, buf[2]=-385, buf[3]=2^35-1, buf[4]=-2^35, shift=8
//    -> 1, 2, -2, 32767, -32768.
//  3 ReLU: buf[0]=-1000, buf[1]=1000, relu=1, shift=2 -> 0, 250. With relu=0 -> -250, 250.
//  4 Backpressure: i_ready toggles 1,0,0,1 and random thereafter -> no beat lost or duplicated;
//    outputs stable while stalled; idx sequence 0..9 exactly once.
//  5 Overlap: i_finish at idx 4 -> ignored, o_overrun=1. i_finish coincident with the idx-9 accept
//    -> o_done pulses and the next cycle shows idx 0 of the new snapshot.
//  6 Reset at idx 5 with o_valid=1 -> next cycle all outputs 0, no o_done. A following finish
//    drains normally from idx 0.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared PE definitions: partial-sum/activation types and drain FSM states.
package pe_pkg;
  localparam int NUM_BUF = 10;
  localparam int PSUM_W  = 36;
  localparam int OUT_W   = 16;
  localparam int SHIFT_W = 6;
  localparam int IDX_W   = $clog2(NUM_BUF);

  typedef logic signed [PSUM_W-1:0] psum_t;
  typedef logic signed [OUT_W-1:0]  act_t;

  typedef enum logic {IDLE, DRAIN} drain_state_e;
endpackage

// File: rtl/pe_requant.sv
// Combinational requantizer: optional ReLU, round-half-up arithmetic right shift,
// signed saturation from PSUM_W down to OUT_W.
module pe_requant
  import pe_pkg::*;
(
  input  psum_t              i_x,
  input  logic               i_relu,
  input  logic [SHIFT_W-1:0] i_shift,
  output act_t               o_y
);
  // One extra bit so adding the rounding constant can never overflow.
  typedef logic signed [PSUM_W:0] wide_t;

  localparam wide_t SAT_MAX = wide_t'((1 << (OUT_W - 1)) - 1);
  localparam wide_t SAT_MIN = -SAT_MAX - wide_t'(1);

  wide_t w_r;
  wide_t w_sum;
  wide_t w_s;

  always_comb begin
    // NOTE: every variable gets a value on every path, so no latch is inferred.
    w_r   = (i_relu && i_x < 0) ? '0 : wide_t'(i_x);
    w_sum = w_r;
    if (i_shift != '0) begin
      w_sum = w_r + (wide_t'(1) <<< (i_shift - SHIFT_W'(1)));
    end
    w_s = w_sum >>> i_shift;

    if (w_s > SAT_MAX) begin
      o_y = act_t'(SAT_MAX);
    end else if (w_s < SAT_MIN) begin
      o_y = act_t'(SAT_MIN);
    end else begin
      o_y = act_t'(w_s);
    end
  end
endmodule

// File: rtl/pe_psum_drain.sv
// Snapshots the reducer's partial sums on i_finish and streams requantized
// activations out one per beat over a valid/ready handshake.
module pe_psum_drain
  import pe_pkg::*;
(
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_finish,
  input  logic [NUM_BUF-1:0][PSUM_W-1:0]   i_buf,
  input  logic                             i_relu_en,
  input  logic [SHIFT_W-1:0]               i_shift,
  input  logic                             i_ready,
  output logic                             o_valid,
  output act_t                             o_data,
  output logic [IDX_W-1:0]                 o_idx,
  output logic                             o_last,
  output logic                             o_busy,
  output logic                             o_done,
  output logic                             o_overrun
);
  drain_state_e                     r_state;
  logic [NUM_BUF-1:0][PSUM_W-1:0]   r_snap;
  logic                             r_relu;
  logic [SHIFT_W-1:0]               r_shift;
  logic                             r_valid;
  act_t                             r_data;
  logic [IDX_W-1:0]                 r_idx;
  logic                             r_last;
  logic                             r_busy;
  logic                             r_done;
  logic                             r_overrun;

  logic                             w_accept;
  logic                             w_load;
  logic [IDX_W-1:0]                 w_next_idx;
  psum_t                            w_req_x;
  logic                             w_req_relu;
  logic [SHIFT_W-1:0]               w_req_shift;
  act_t                             w_req_y;

  // The single requantizer sees either the incoming buffer (fresh snapshot)
  // or the held snapshot at the next index, so o_data can be registered.
  always_comb begin
    w_accept    = r_valid && i_ready;
    w_load      = i_finish && (r_state == IDLE || (w_accept && r_last));
    w_next_idx  = r_last ? '0 : r_idx + IDX_W'(1);
    w_req_x     = psum_t'(r_snap[w_next_idx]);
    w_req_relu  = r_relu;
    w_req_shift = r_shift;
    if (w_load) begin
      w_req_x     = psum_t'(i_buf[0]);
      w_req_relu  = i_relu_en;
      w_req_shift = i_shift;
    end
  end

  pe_requant u_requant (
    .i_x     (w_req_x),
    .i_relu  (w_req_relu),
    .i_shift (w_req_shift),
    .o_y     (w_req_y)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= IDLE;
      // NOTE: the snapshot is a plain register array, so clearing it on reset is cheap and makes the idle state fully defined.
      r_snap    <= '0;
      r_relu    <= 1'b0;
      r_shift   <= '0;
      r_valid   <= 1'b0;
      r_data    <= '0;
      r_idx     <= '0;
      r_last    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here; later statements override earlier ones within the same edge.
      r_done <= 1'b0;
      case (r_state)
        IDLE: ;
        DRAIN: begin
          if (i_finish && !(w_accept && r_last)) begin
            r_overrun <= 1'b1;
          end
          if (w_accept) begin
            if (r_last) begin
              r_done  <= 1'b1;
              r_state <= IDLE;
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
              r_idx   <= '0;
              r_last  <= 1'b0;
            end else begin
              r_idx  <= w_next_idx;
              r_last <= (w_next_idx == IDX_W'(NUM_BUF - 1));
              r_data <= w_req_y;
            end
          end
        end
        default: r_state <= IDLE;
      endcase

      // A new snapshot wins over the return to IDLE on a coincident final accept.
      if (w_load) begin
        r_snap  <= i_buf;
        r_relu  <= i_relu_en;
        r_shift <= i_shift;
        r_state <= DRAIN;
        r_valid <= 1'b1;
        r_busy  <= 1'b1;
        r_idx   <= '0;
        r_last  <= (NUM_BUF == 1);
        r_data  <= w_req_y;
      end
    end
  end

  assign o_valid   = r_valid;
  assign o_data    = r_data;
  assign o_idx     = r_idx;
  assign o_last    = r_last;
  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_overrun = r_overrun;
endmodule
